// File: rtl/scan_display_pkg.sv
// Shared types and default constants for the scan_display row-multiplexed LED driver.
package scan_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_LOAD,
    ST_DISPLAY,
    ST_BLANK
  } state_e;

  localparam int FRAME_BITS_DEF   = 72;
  localparam int NUM_ROWS_DEF     = 4;
  localparam int SCLK_DIV_DEF     = 16;
  localparam int LOAD_CYCLES_DEF  = 8;
  localparam int DISP_SCALE_DEF   = 16;
  localparam int BLANK_CYCLES_DEF = 64;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scan_display_if.sv
// Host-side inputs and panel-side outputs of scan_display, bundled for port connection.
interface scan_display_if #(
  parameter int FRAME_BITS = 72,
  parameter int NUM_ROWS   = 4
);
  logic                           enable;
  logic [FRAME_BITS*NUM_ROWS-1:0] display_bits;
  logic [7:0]                     brightness;
  logic                           sclk;
  logic                           sdata;
  logic                           sload;
  logic                           sclr_n;
  logic                           oe_n;
  logic [NUM_ROWS-1:0]            row_sel;
  logic                           frame_start;

  modport master (
    output enable, display_bits, brightness,
    input  sclk, sdata, sload, sclr_n, oe_n, row_sel, frame_start
  );

  modport slave (
    input  enable, display_bits, brightness,
    output sclk, sdata, sload, sclr_n, oe_n, row_sel, frame_start
  );
endinterface

// File: rtl/scan_display_serial_shifter.sv
// Serialises one snapshotted row LSB first; sdata moves only on the sclk-low half.
module serial_shifter
  import scan_display_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int SCLK_DIV   = SCLK_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] din,
  output logic                  sclk,
  output logic                  sdata,
  output logic                  done
);
  localparam int BIT_W = clog2_min1(FRAME_BITS);
  localparam int PH_W  = clog2_min1(2 * SCLK_DIV);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(2 * SCLK_DIV - 1);
  localparam logic [PH_W-1:0]  HI_PH    = PH_W'(SCLK_DIV);

  logic                  active_q, active_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic [FRAME_BITS-1:0] buf_q, buf_d;
  logic                  sclk_q, sclk_d;
  logic                  sdata_q, sdata_d;

  // High during the final cycle of the last bit, so the sequencer leaves SHIFT on time.
  assign done  = active_q && (bit_q == LAST_BIT) && (ph_q == LAST_PH);
  assign sclk  = sclk_q;
  assign sdata = sdata_q;

  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    ph_d     = ph_q;
    buf_d    = buf_q;
    if (start) begin
      active_d = 1'b1;
      bit_d    = '0;
      ph_d     = '0;
      buf_d    = din;
    end else if (active_q) begin
      if (ph_q == LAST_PH) begin
        ph_d = '0;
        if (bit_q == LAST_BIT) begin
          active_d = 1'b0;
        end else begin
          bit_d = bit_q + 1'b1;
          buf_d = buf_q >> 1;
        end
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end
    // Registered from next-state values so both lines line up with the sequencer's SHIFT cycles.
    sclk_d  = active_d && (ph_d >= HI_PH);
    sdata_d = active_d && buf_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      bit_q    <= '0;
      ph_q     <= '0;
      buf_q    <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      buf_q    <= buf_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
    end
  end

endmodule

// File: rtl/scan_display.sv
// Row sequencer: CLEAR, SHIFT, LOAD, DISPLAY (PWM on oe_n), BLANK, then the next row.
module scan_display
  import scan_display_pkg::*;
#(
  parameter int FRAME_BITS   = FRAME_BITS_DEF,
  parameter int NUM_ROWS     = NUM_ROWS_DEF,
  parameter int SCLK_DIV     = SCLK_DIV_DEF,
  parameter int LOAD_CYCLES  = LOAD_CYCLES_DEF,
  parameter int DISP_SCALE   = DISP_SCALE_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst_n,
  scan_display_if.slave bus
);
  localparam int DISP_LEN = 256 * DISP_SCALE;
  localparam int CNT_W    = clog2_min1(max3(LOAD_CYCLES, DISP_LEN, BLANK_CYCLES));
  localparam int ROW_W    = clog2_min1(NUM_ROWS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [7:0]           bright_q, bright_d;
  logic                 sload_q, sload_d;
  logic                 sclr_n_q, sclr_n_d;
  logic                 oe_n_q, oe_n_d;
  logic [NUM_ROWS-1:0]  row_sel_q, row_sel_d;
  logic                 frame_start_q, frame_start_d;

  logic [FRAME_BITS-1:0] row_bits;
  logic [NUM_ROWS-1:0]   row_onehot;
  logic [CNT_W-1:0]      on_len;
  logic                  shift_start, shift_done;

  assign row_bits    = bus.display_bits[int'(row_q) * FRAME_BITS +: FRAME_BITS];
  assign row_onehot  = NUM_ROWS'(1) << row_q;
  assign shift_start = (state_q == ST_CLEAR);

  serial_shifter #(
    .FRAME_BITS(FRAME_BITS),
    .SCLK_DIV  (SCLK_DIV)
  ) u_shifter (
    .clk  (clk),
    .rst_n(rst_n),
    .start(shift_start),
    .din  (row_bits),
    .sclk (bus.sclk),
    .sdata(bus.sdata),
    .done (shift_done)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    bright_d = bright_q;
    unique case (state_q)
      ST_IDLE:    if (bus.enable) state_d = ST_CLEAR;
      ST_CLEAR:   state_d = ST_SHIFT;
      ST_SHIFT:   if (shift_done) state_d = ST_LOAD;
      ST_LOAD:    if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) state_d = ST_DISPLAY;
      ST_DISPLAY: if (cnt_q == CNT_W'(DISP_LEN - 1)) state_d = ST_BLANK;
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          // Row advances even when stopping, so a restart resumes at the following row.
          row_d   = (row_q == ROW_W'(NUM_ROWS - 1)) ? '0 : row_q + 1'b1;
          state_d = bus.enable ? ST_CLEAR : ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase

    if (state_d != state_q || state_q == ST_IDLE || state_q == ST_CLEAR || state_q == ST_SHIFT)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    if (state_q == ST_LOAD && state_d == ST_DISPLAY)
      bright_d = bus.brightness;
    on_len = CNT_W'(bright_d) * CNT_W'(DISP_SCALE);

    sload_d       = (state_d == ST_LOAD);
    sclr_n_d      = (state_d != ST_CLEAR);
    frame_start_d = (state_d == ST_CLEAR) && (row_d == '0);
    oe_n_d        = !((state_d == ST_DISPLAY) && (cnt_d < on_len));

    // A single row never changes, so it is driven from the moment scanning starts.
    row_sel_d = row_sel_q;
    if (state_d == ST_IDLE)
      row_sel_d = '0;
    else if ((state_d == ST_LOAD && state_q != ST_LOAD) || NUM_ROWS == 1)
      row_sel_d = row_onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      row_q         <= '0;
      bright_q      <= '0;
      sload_q       <= 1'b0;
      sclr_n_q      <= 1'b1;
      oe_n_q        <= 1'b1;
      row_sel_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      bright_q      <= bright_d;
      sload_q       <= sload_d;
      sclr_n_q      <= sclr_n_d;
      oe_n_q        <= oe_n_d;
      row_sel_q     <= row_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.sload       = sload_q;
  assign bus.sclr_n      = sclr_n_q;
  assign bus.oe_n        = oe_n_q;
  assign bus.row_sel     = row_sel_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_scan_display.sv
// Self-checking bench for scan_display: row-period model, vector table, corner sequences.
module tb_scan_display;
  localparam int FB = 8, NR = 2, SD = 2, LC = 2, DS = 1, BC = 4;
  localparam int T_LOAD  = 1 + FB * 2 * SD;
  localparam int T_DISP  = T_LOAD + LC;
  localparam int T_BLANK = T_DISP + 256 * DS;
  localparam int ROW_T   = T_BLANK + BC;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  scan_display_if #(.FRAME_BITS(FB), .NUM_ROWS(NR)) bus ();

  scan_display #(
    .FRAME_BITS(FB), .NUM_ROWS(NR), .SCLK_DIV(SD),
    .LOAD_CYCLES(LC), .DISP_SCALE(DS), .BLANK_CYCLES(BC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: position t inside a 295-cycle row period plus latched snapshot/brightness.
  bit           m_run;
  int           m_t;
  int           m_row;
  logic [FB-1:0] m_snap;
  int           m_bri;
  logic [NR-1:0] m_rsel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_t    <= 0;
      m_row  <= 0;
      m_snap <= '0;
      m_bri  <= 0;
      m_rsel <= '0;
    end else if (!m_run) begin
      if (bus.enable) begin
        m_run <= 1'b1;
        m_t   <= 0;
      end
    end else begin
      if (m_t == 0) m_snap <= bus.display_bits[m_row*FB +: FB];
      if (m_t == T_LOAD - 1) m_rsel <= NR'(1 << m_row);
      if (m_t == T_DISP - 1) m_bri <= int'(bus.brightness);
      if (m_t == ROW_T - 1) begin
        m_row <= (m_row + 1) % NR;
        m_t   <= 0;
        if (!bus.enable) begin
          m_run  <= 1'b0;
          m_rsel <= '0;
        end
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  function automatic logic [7:0] exp_out();
    logic sc = 0, sd = 0, sl = 0, cl = 1, oe = 1, fs = 0;
    int k;
    if (m_run) begin
      if (m_t == 0) begin
        cl = 0;
        fs = (m_row == 0);
      end else if (m_t < T_LOAD) begin
        k  = m_t - 1;
        sc = (k % (2 * SD)) >= SD;
        sd = m_snap[k / (2 * SD)];
      end else if (m_t < T_DISP) begin
        sl = 1;
      end else if (m_t < T_BLANK) begin
        oe = !((m_t - T_DISP) < m_bri * DS);
      end
    end
    return {sc, sd, sl, cl, oe, m_rsel, fs};
  endfunction

  function automatic logic [7:0] act_out();
    return {bus.sclk, bus.sdata, bus.sload, bus.sclr_n, bus.oe_n, bus.row_sel, bus.frame_start};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every cycle advance goes through here so the model comparison runs each cycle.
  task automatic step();
    logic [7:0] a, e;
    @(negedge clk);
    a = act_out();
    e = exp_out();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle_model at %0t got %b expected %b", $time, a, e);
    end
  endtask

  task automatic do_reset();
    step();
    #2 rst_n = 1'b0;
    bus.enable = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_clear(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 700 && !ok; i++) begin
      step();
      if (!bus.sclr_n) ok = 1'b1;
    end
    if (!ok) check("wait_clear_timeout", 0, 1);
  endtask

  // Observes one full row period starting at its CLEAR cycle (sample 0).
  task automatic measure_row(input int chg_at, input logic [FB*NR-1:0] chg_val,
                             output logic [7:0] seq, output int oe_low, output int sl_n,
                             output int clr_n, output int first_rise, output int viol);
    bit ok;
    logic prev_sclk, prev_sdata;
    seq = '0; oe_low = 0; sl_n = 0; clr_n = 0; first_rise = -1; viol = 0;
    wait_clear(ok);
    prev_sclk = 1'b0;
    prev_sdata = 1'b0;
    for (int n = 0; n < ROW_T; n++) begin
      if (n > 0) step();
      if (n == chg_at) bus.display_bits = chg_val;
      if (bus.sclk && !prev_sclk) begin
        seq = {seq[6:0], bus.sdata};
        if (first_rise < 0) first_rise = n;
      end
      if (bus.sclk && bus.sdata != prev_sdata) viol++;
      prev_sclk  = bus.sclk;
      prev_sdata = bus.sdata;
      if (!bus.oe_n)   oe_low++;
      if (bus.sload)   sl_n++;
      if (!bus.sclr_n) clr_n++;
    end
  endtask

  typedef struct {
    logic [7:0] bri;
    logic [7:0] row0;
    logic [7:0] row1;
    logic [7:0] exp_seq;  // sdata at successive sclk rises, first bit in bit 7
    int         exp_oe;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] seq;
    int oe_low, sl_n, clr_n, fr, viol, p2, n;
    bit ok;
    logic [NR-1:0] prev_rs;
    logic [NR-1:0] rs_q[$];

    vecs[0] = '{bri: 8'h40, row0: 8'hA5, row1: 8'h11, exp_seq: 8'hA5, exp_oe: 64};
    vecs[1] = '{bri: 8'h00, row0: 8'h01, row1: 8'hFF, exp_seq: 8'h80, exp_oe: 0};
    vecs[2] = '{bri: 8'hFF, row0: 8'hF0, row1: 8'h3C, exp_seq: 8'h0F, exp_oe: 255};
    vecs[3] = '{bri: 8'h01, row0: 8'h35, row1: 8'h00, exp_seq: 8'hAC, exp_oe: 1};

    bus.enable = 1'b0;
    bus.display_bits = '0;
    bus.brightness = '0;
    #1 rst_n = 1'b0;
    #2 check("reset_outputs", int'(act_out()), int'(8'b0001_1000));
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_row_sel", int'(bus.row_sel), 0);

    // Table: one row-0 pass per vector
    for (int v = 0; v < 4; v++) begin
      do_reset();
      bus.brightness   = vecs[v].bri;
      bus.display_bits = {vecs[v].row1, vecs[v].row0};
      bus.enable       = 1'b1;
      measure_row(-1, '0, seq, oe_low, sl_n, clr_n, fr, viol);
      check($sformatf("v%0d_seq", v), int'(seq), int'(vecs[v].exp_seq));
      check($sformatf("v%0d_oe_low", v), oe_low, vecs[v].exp_oe);
      check($sformatf("v%0d_sload_cycles", v), sl_n, LC);
      check($sformatf("v%0d_sclr_low", v), clr_n, 1);
      check($sformatf("v%0d_first_rise", v), fr, 3);
      check($sformatf("v%0d_sdata_while_high", v), viol, 0);
    end

    // Continuous run: frame period and row_sel order
    do_reset();
    bus.brightness = 8'h20;
    bus.display_bits = 16'h1234;
    bus.enable = 1'b1;
    wait_clear(ok);
    check("frame_start_first_clear", int'(bus.frame_start), 1);
    p2 = -1; n = 0;
    prev_rs = bus.row_sel;
    for (int i = 0; i < 700; i++) begin
      step();
      n++;
      if (bus.frame_start && p2 < 0) p2 = n;
      if (bus.row_sel != prev_rs) rs_q.push_back(bus.row_sel);
      prev_rs = bus.row_sel;
    end
    check("frame_period", p2, 2 * ROW_T);
    check("row_sel_changes", (rs_q.size() >= 3) ? 1 : 0, 1);
    if (rs_q.size() >= 3) begin
      check("row_sel_0", int'(rs_q[0]), 1);
      check("row_sel_1", int'(rs_q[1]), 2);
      check("row_sel_2", int'(rs_q[2]), 1);
    end

    // display_bits changed mid-SHIFT: snapshot shifts now, new value on next pass
    do_reset();
    bus.brightness = 8'h08;
    bus.display_bits = {8'h00, 8'h35};
    bus.enable = 1'b1;
    measure_row(5, {8'h00, 8'h0F}, seq, oe_low, sl_n, clr_n, fr, viol);
    check("snap_seq", int'(seq), int'(8'hAC));
    measure_row(-1, '0, seq, oe_low, sl_n, clr_n, fr, viol);
    check("snap_row1_seq", int'(seq), 0);
    measure_row(-1, '0, seq, oe_low, sl_n, clr_n, fr, viol);
    check("snap_next_pass_seq", int'(seq), int'(8'hF0));

    // enable dropped mid-SHIFT of row 0
    do_reset();
    bus.brightness = 8'h10;
    bus.display_bits = {8'h42, 8'h81};
    bus.enable = 1'b1;
    wait_clear(ok);
    repeat (10) step();
    bus.enable = 1'b0;
    sl_n = 0; oe_low = 0;
    for (int i = 0; i < 320; i++) begin
      step();
      if (bus.sload) sl_n++;
      if (!bus.oe_n) oe_low++;
    end
    check("drop_sload_cycles", sl_n, LC);
    check("drop_oe_low", oe_low, 16);
    check("drop_idle_row_sel", int'(bus.row_sel), 0);
    check("drop_idle_oe_n", int'(bus.oe_n), 1);
    bus.enable = 1'b1;
    wait_clear(ok);
    check("resume_no_frame_start", int'(bus.frame_start), 0);
    repeat (T_LOAD) step();
    check("resume_row_sel", int'(bus.row_sel), 2);

    // Reset mid-DISPLAY
    do_reset();
    bus.brightness = 8'h80;
    bus.enable = 1'b1;
    wait_clear(ok);
    repeat (100) step();
    check("pre_reset_oe_n", int'(bus.oe_n), 0);
    #2 rst_n = 1'b0;
    #1 check("async_oe_n", int'(bus.oe_n), 1);
    check("async_row_sel", int'(bus.row_sel), 0);
    step();
    rst_n = 1'b1;
    wait_clear(ok);
    check("post_reset_frame_start", int'(bus.frame_start), 1);

    // Random traffic against the model
    for (int i = 0; i < 250; i++) begin
      step();
      bus.brightness   = 8'($urandom);
      bus.display_bits = 16'($urandom);
      if ($urandom_range(7) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(49) == 0) begin
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(60, 5)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_display.md
SCAN_DISPLAY -- requirements
Module: scan_display

Interface
REQ-001 Parameter FRAME_BITS, default 72: bits shifted per row.
REQ-002 Parameter NUM_ROWS, default 4: multiplexed rows (1..16).
REQ-003 Parameter SCLK_DIV, default 16: sclk half-period in clk cycles (>=1).
REQ-004 Parameter LOAD_CYCLES, default 8: sload high duration in clk cycles (>=1).
REQ-005 Parameter DISP_SCALE, default 16: DISPLAY period is 256*DISP_SCALE clk cycles.
REQ-006 Parameter BLANK_CYCLES, default 64: post-display blanking in clk cycles (>=1).
REQ-007 clk  input  1  system clock.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 enable  input  1  run scanning; low parks the block in IDLE.
REQ-010 display_bits  input  FRAME_BITS*NUM_ROWS  row r in slice [r*FRAME_BITS +: FRAME_BITS].
REQ-011 brightness  input  8  display duty, 0 = dark, 255 = 255/256.
REQ-012 sclk  output  1  shift-register clock.
REQ-013 sdata  output  1  serial data, bit 0 of the row first.
REQ-014 sload  output  1  output-latch strobe.
REQ-015 sclr_n  output  1  shift-register clear, active-low.
REQ-016 oe_n  output  1  driver output enable, active-low.
REQ-017 row_sel  output  NUM_ROWS  one-hot row drive; all-zero in IDLE.
REQ-018 frame_start  output  1  one-cycle pulse at the start of row 0.

Function
REQ-019 States: IDLE, CLEAR, SHIFT, LOAD, DISPLAY, BLANK; all outputs registered.
REQ-020 IDLE -> CLEAR when enable=1; BLANK end -> CLEAR if enable=1, else IDLE.
REQ-021 CLEAR lasts 1 cycle: sclr_n=0, snapshot current row slice into an internal shift buffer; frame_start=1 when row index=0.
REQ-022 SHIFT lasts FRAME_BITS*2*SCLK_DIV cycles; bit i is driven on sdata for 2*SCLK_DIV cycles; sclk low for the first SCLK_DIV cycles and high for the second.
REQ-023 sdata changes only while sclk is low; the shifted data is the snapshot, not live display_bits.
REQ-024 LOAD lasts LOAD_CYCLES cycles: sload=1, sclk=0, sdata=0; row_sel updates to the current row on LOAD entry.
REQ-025 DISPLAY lasts 256*DISP_SCALE cycles; brightness is sampled on entry; oe_n=0 for the first brightness*DISP_SCALE cycles, 1 for the rest.
REQ-026 BLANK lasts BLANK_CYCLES cycles with oe_n=1; the row index increments on BLANK exit, wrapping NUM_ROWS-1 -> 0.
REQ-027 oe_n=1 in every state except DISPLAY; sclk=0 and sdata=0 outside SHIFT.
REQ-028 enable deasserted mid-row: the current row completes through BLANK, then IDLE; row index is kept, so the next start resumes at the following row.
REQ-029 brightness changes during DISPLAY take effect at the next DISPLAY only.
REQ-030 NUM_ROWS=1: row_sel stays 1 outside IDLE; frame_start pulses every row period.

Reset
REQ-031 Asynchronous reset forces immediately: state=IDLE, row index=0, sclk=0, sdata=0, sload=0, sclr_n=1, oe_n=1, row_sel=0, frame_start=0.
REQ-032 Reset mid-operation discards the partial row; after release the block restarts at row 0 with a full CLEAR.

Structure
REQ-033 Shared package holds the state enumeration and the parameter default constants.
REQ-034 Sub-module serial_shifter (FRAME_BITS, SCLK_DIV) owns the snapshot buffer, bit counter and sclk/sdata generation, with start/done handshake to the sequencer.

Verification (FRAME_BITS=8, NUM_ROWS=2, SCLK_DIV=2, LOAD_CYCLES=2, DISP_SCALE=1, BLANK_CYCLES=4; row period 295 cycles)
REQ-035 Row0=0xA5, enable=1 -> sdata at the 8 sclk rising edges = 1,0,1,0,0,1,0,1; first rise at SHIFT cycle 2; sload high 2 cycles.
REQ-036 brightness=0x40 -> oe_n low exactly 64 cycles per DISPLAY; 0x00 -> never low; 0xFF -> 255 cycles.
REQ-037 Continuous run -> frame_start period 590 cycles; row_sel sequence 01,10,01; sclr_n low 1 cycle per row.
REQ-038 display_bits changed mid-SHIFT -> shifted bits equal the CLEAR snapshot; the new value appears on the next pass.
REQ-039 enable dropped mid-SHIFT of row 0 -> row completes through BLANK, then IDLE with row_sel=0 and oe_n=1; re-enable starts at row 1.
REQ-040 rst_n asserted mid-DISPLAY -> oe_n=1 and row_sel=0 in the same cycle; after release the first frame_start occurs in the first CLEAR.
